// File: rtl/battle_arbiter.sv
// battle_arbiter: frame-rate referee that owns the authoritative tile map, merges
// brick destruction reported by both tanks, detects bullet hits and runs the round/score FSM.
module battle_arbiter #(
  parameter int MAP_W       = 20,
  parameter int MAP_H       = 15,
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic signed [31:0] p1_map [MAP_W*MAP_H],
  input  logic signed [31:0] p2_map [MAP_W*MAP_H],
  input  logic signed [31:0] Tank1X,
  input  logic signed [31:0] Tank1Y,
  input  logic signed [31:0] Tank2X,
  input  logic signed [31:0] Tank2Y,
  input  logic signed [31:0] Bul1X,
  input  logic signed [31:0] Bul1Y,
  input  logic signed [31:0] Bul2X,
  input  logic signed [31:0] Bul2Y,
  output logic signed [31:0] map_out [MAP_W*MAP_H],
  output logic [3:0]         score1,
  output logic [3:0]         score2,
  output logic               hit1,
  output logic               hit2,
  output logic               round_reset,
  output logic [1:0]         game_state,
  output logic [1:0]         winner
);

  localparam int N_TILES = MAP_W * MAP_H;
  localparam int CNT_W   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [1:0]       TILE_EMPTY = 2'd0;
  localparam logic [1:0]       TILE_WALL  = 2'd1;
  localparam logic [1:0]       TILE_BRICK = 2'd2;
  localparam logic [3:0]       WIN_Q      = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Power-on layout: walled border, a lattice of bricks, spawn tiles kept clear.
  function automatic logic [1:0] init_tile(input int idx);
    int x;
    int y;
    x = idx % MAP_W;
    y = idx / MAP_W;
    if (x == 0 || x == MAP_W - 1 || y == 0 || y == MAP_H - 1) return TILE_WALL;
    if ((x == 1 && y == MAP_H - 2) || (x == MAP_W - 2 && y == 1)) return TILE_EMPTY;
    if (x % 4 == 3 && y % 3 == 2) return TILE_BRICK;
    return TILE_EMPTY;
  endfunction

  // Off-map coordinates (including the -1 "no bullet" marker) never register a hit.
  function automatic logic on_tank(input logic signed [31:0] bx, input logic signed [31:0] by,
                                   input logic signed [31:0] tx, input logic signed [31:0] ty);
    return (bx >= 0) && (bx < MAP_W) && (by >= 0) && (by < MAP_H) && (bx == tx) && (by == ty);
  endfunction

  logic [1:0]       map_q [N_TILES];
  logic [1:0]       map_d [N_TILES];
  logic [3:0]       score1_q, score1_d;
  logic [3:0]       score2_q, score2_d;
  logic             hit1_q, hit1_d;
  logic             hit2_q, hit2_d;
  logic             rr_q, rr_d;
  logic [1:0]       winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;

  // NOTE: every variable gets its default before the case so no path can leave it
  // unassigned; a missed default would infer a latch.
  always_comb begin
    map_d    = map_q;
    score1_d = score1_q;
    score2_d = score2_q;
    hit1_d   = 1'b0;
    hit2_d   = 1'b0;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    state_d  = state_q;

    unique case (state_q)
      ST_PLAY: begin
        for (int i = 0; i < N_TILES; i++) begin
          if (map_q[i] == TILE_BRICK && (p1_map[i] == '0 || p2_map[i] == '0)) begin
            map_d[i] = TILE_EMPTY;
          end
        end
        hit1_d = on_tank(Bul2X, Bul2Y, Tank1X, Tank1Y);
        hit2_d = on_tank(Bul1X, Bul1Y, Tank2X, Tank2Y);
        if (hit1_d || hit2_d) begin
          score1_d = score1_q + {3'b000, hit2_d};
          score2_d = score2_q + {3'b000, hit1_d};
          if (score1_d == WIN_Q || score2_d == WIN_Q) begin
            state_d  = ST_OVER;
            winner_d = {score2_d == WIN_Q, score1_d == WIN_Q};
          end else begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Pulse lands on the final HOLD cycle, so tanks restart as PLAY resumes.
    rr_d = (state_d == ST_HOLD) && (cnt_d == HOLD_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      // NOTE: the map array is deliberately reset; restoring the brick layout is a
      // functional requirement, not just initialisation.
      for (int i = 0; i < N_TILES; i++) map_q[i] <= init_tile(i);
      score1_q <= '0;
      score2_q <= '0;
      hit1_q   <= 1'b0;
      hit2_q   <= 1'b0;
      rr_q     <= 1'b0;
      winner_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_PLAY;
    end else begin
      for (int i = 0; i < N_TILES; i++) map_q[i] <= map_d[i];
      score1_q <= score1_d;
      score2_q <= score2_d;
      hit1_q   <= hit1_d;
      hit2_q   <= hit2_d;
      rr_q     <= rr_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_TILES; i++) map_out[i] = 32'(map_q[i]);
  end

  assign score1      = score1_q;
  assign score2      = score2_q;
  assign hit1        = hit1_q;
  assign hit2        = hit2_q;
  assign round_reset = rr_q;
  assign game_state  = state_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_battle_arbiter.sv
// tb_battle_arbiter: directed scenarios plus randomized play, each frame compared
// against a frame-level reference model of the referee rules.
module tb_battle_arbiter;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;
  localparam int N     = MAP_W * MAP_H;
  localparam int WIN   = 3;
  localparam int HOLD  = 60;

  logic               frame_clk = 1'b0;
  logic               Reset;
  logic signed [31:0] p1_map [N];
  logic signed [31:0] p2_map [N];
  logic signed [31:0] map_out [N];
  logic signed [31:0] Tank1X, Tank1Y, Tank2X, Tank2Y;
  logic signed [31:0] Bul1X, Bul1Y, Bul2X, Bul2Y;
  logic [3:0]         score1, score2;
  logic               hit1, hit2, round_reset;
  logic [1:0]         game_state, winner;

  always #5 frame_clk = ~frame_clk;

  battle_arbiter #(.MAP_W(MAP_W), .MAP_H(MAP_H), .WIN_SCORE(WIN), .HOLD_FRAMES(HOLD)) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .p1_map     (p1_map),
    .p2_map     (p2_map),
    .Tank1X     (Tank1X),
    .Tank1Y     (Tank1Y),
    .Tank2X     (Tank2X),
    .Tank2Y     (Tank2Y),
    .Bul1X      (Bul1X),
    .Bul1Y      (Bul1Y),
    .Bul2X      (Bul2X),
    .Bul2Y      (Bul2Y),
    .map_out    (map_out),
    .score1     (score1),
    .score2     (score2),
    .hit1       (hit1),
    .hit2       (hit2),
    .round_reset(round_reset),
    .game_state (game_state),
    .winner     (winner)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model: phase 0 play, 1 hold, 2 over; hold_frames counts HOLD cycles seen.
  int m_map [N];
  int m_s1, m_s2, m_phase, m_hold_frames, m_win;
  int m_h1, m_h2, m_rr;

  function automatic int layout(input int x, input int y);
    if (x == 0 || x == MAP_W - 1 || y == 0 || y == MAP_H - 1) return 1;
    if ((x == 1 && y == 13) || (x == 18 && y == 1)) return 0;
    if (x % 4 == 3 && y % 3 == 2) return 2;
    return 0;
  endfunction

  function automatic int struck(input int bx, input int by, input int tx, input int ty);
    if (bx < 0 || bx >= MAP_W || by < 0 || by >= MAP_H) return 0;
    return (bx == tx && by == ty) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int y = 0; y < MAP_H; y++)
      for (int x = 0; x < MAP_W; x++) m_map[y * MAP_W + x] = layout(x, y);
    m_s1 = 0; m_s2 = 0; m_phase = 0; m_hold_frames = 0; m_win = 0;
    m_h1 = 0; m_h2 = 0; m_rr = 0;
  endtask

  task automatic model_step();
    if (Reset) begin
      model_reset();
      return;
    end
    m_h1 = 0; m_h2 = 0; m_rr = 0;
    if (m_phase == 0) begin
      for (int i = 0; i < N; i++)
        if (m_map[i] == 2 && (int'(p1_map[i]) == 0 || int'(p2_map[i]) == 0)) m_map[i] = 0;
      m_h2 = struck(int'(Bul1X), int'(Bul1Y), int'(Tank2X), int'(Tank2Y));
      m_h1 = struck(int'(Bul2X), int'(Bul2Y), int'(Tank1X), int'(Tank1Y));
      if (m_h1 + m_h2 > 0) begin
        m_s1 += m_h2;
        m_s2 += m_h1;
        if (m_s1 == WIN || m_s2 == WIN) begin
          m_phase = 2;
          m_win = (m_s1 == WIN && m_s2 == WIN) ? 3 : (m_s1 == WIN) ? 1 : 2;
        end else begin
          m_phase = 1;
          m_hold_frames = 1;
          m_rr = (HOLD == 1) ? 1 : 0;
        end
      end
    end else if (m_phase == 1) begin
      if (m_hold_frames == HOLD) m_phase = 0;
      else begin
        m_hold_frames++;
        m_rr = (m_hold_frames == HOLD) ? 1 : 0;
      end
    end
  endtask

  task automatic compare_all();
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) if (map_out[i] !== 32'(m_map[i])) bad++;
    check("map_tiles_wrong", bad, 0);
    check("score1", int'(score1), m_s1);
    check("score2", int'(score2), m_s2);
    check("hit1", int'(hit1), m_h1);
    check("hit2", int'(hit2), m_h2);
    check("round_reset", int'(round_reset), m_rr);
    check("game_state", int'(game_state), m_phase);
    check("winner", int'(winner), m_win);
  endtask

  // Inputs are held across the edge; the model consumes them just before it.
  task automatic step();
    model_step();
    @(posedge frame_clk);
    #1;
    compare_all();
  endtask

  task automatic mirror_maps();
    for (int i = 0; i < N; i++) begin
      p1_map[i] = m_map[i];
      p2_map[i] = m_map[i];
    end
  endtask

  task automatic no_bullets();
    Bul1X = -1; Bul1Y = -1; Bul2X = -1; Bul2Y = -1;
  endtask

  task automatic spawn_tanks();
    Tank1X = 1; Tank1Y = 13; Tank2X = 18; Tank2Y = 1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic both_hit();
    Bul1X = Tank2X; Bul1Y = Tank2Y; Bul2X = Tank1X; Bul2Y = Tank1Y;
  endtask

  int rr_seen;
  int over_cycles;
  int r;

  initial begin
    model_reset();
    no_bullets();
    spawn_tanks();
    mirror_maps();
    Reset = 1'b1;
    step();
    step();
    check("rst_tile0", int'(map_out[0]), 1);
    check("rst_tile43", int'(map_out[43]), 2);
    check("rst_tile261", int'(map_out[261]), 0);
    check("rst_tile38", int'(map_out[38]), 0);
    check("rst_tile299", int'(map_out[299]), 1);
    check("rst_state", int'(game_state), 0);
    Reset = 1'b0;

    // Brick destroyed by one tank; a wall survives a zero proposal.
    mirror_maps();
    p1_map[43] = 0;
    step();
    check("brick43_cleared", int'(map_out[43]), 0);
    mirror_maps();
    p2_map[0] = 0;
    step();
    check("wall0_kept", int'(map_out[0]), 1);
    mirror_maps();

    // Single hit, bullet left on target through HOLD to show hits are suspended.
    Bul1X = 18; Bul1Y = 1;
    step();
    check("single_hit2", int'(hit2), 1);
    check("single_score1", int'(score1), 1);
    check("single_state_hold", int'(game_state), 1);
    rr_seen = 0;
    for (int k = 0; k < HOLD; k++) begin
      if (k == HOLD - 1) no_bullets();
      step();
      rr_seen += int'(round_reset);
    end
    check("single_rr_pulses", rr_seen, 1);
    check("single_back_to_play", int'(game_state), 0);

    // Simultaneous hits, three rounds in a row end in a draw.
    do_reset();
    for (int round = 1; round <= WIN; round++) begin
      both_hit();
      step();
      check("dual_hit1", int'(hit1), 1);
      check("dual_hit2", int'(hit2), 1);
      check("dual_score1", int'(score1), round);
      check("dual_score2", int'(score2), round);
      no_bullets();
      if (round < WIN) repeat (HOLD) step();
    end
    check("draw_state_over", int'(game_state), 2);
    check("draw_winner", int'(winner), 3);
    both_hit();
    repeat (5) step();
    check("over_score1_sat", int'(score1), WIN);
    no_bullets();

    // Reset in the middle of HOLD restores the map and suppresses round_reset.
    do_reset();
    mirror_maps();
    p2_map[43] = 0;
    step();
    mirror_maps();
    Bul1X = 18; Bul1Y = 1;
    step();
    no_bullets();
    repeat (29) step();
    check("midhold_state", int'(game_state), 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midhold_rst_state", int'(game_state), 0);
    check("midhold_rst_score1", int'(score1), 0);
    check("midhold_rst_tile43", int'(map_out[43]), 2);
    rr_seen = 0;
    repeat (HOLD + 5) begin
      step();
      rr_seen += int'(round_reset);
    end
    check("midhold_no_rr", rr_seen, 0);

    // Randomized play around a small patch so hits happen regularly.
    over_cycles = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      over_cycles = (m_phase == 2) ? over_cycles + 1 : 0;
      Reset = ($urandom_range(0, 299) == 0) || (over_cycles > 8);
      for (int i = 0; i < N; i++) begin
        p1_map[i] = m_map[i];
        p2_map[i] = m_map[i];
        r = int'($urandom_range(0, 99));
        if (r < 3) p1_map[i] = 0;
        else if (r < 5) p1_map[i] = $urandom_range(0, 3);
        r = int'($urandom_range(0, 99));
        if (r < 3) p2_map[i] = 0;
        else if (r < 5) p2_map[i] = -1;
      end
      Tank1X = $urandom_range(0, 2); Tank1Y = $urandom_range(0, 2);
      Tank2X = $urandom_range(0, 2); Tank2Y = $urandom_range(0, 2);
      Bul1X = int'($urandom_range(0, 4)) - 1; Bul1Y = int'($urandom_range(0, 3)) - 1;
      Bul2X = int'($urandom_range(0, 4)) - 1; Bul2Y = int'($urandom_range(0, 3)) - 1;
      r = int'($urandom_range(0, 29));
      if (r == 0) begin
        Tank2X = MAP_W; Tank2Y = 0; Bul1X = MAP_W; Bul1Y = 0;
      end else if (r == 1) begin
        Tank1X = -1; Tank1Y = -1; Bul2X = -1; Bul2Y = -1;
      end else if (r == 2) begin
        Tank1X = 0; Tank1Y = MAP_H; Bul2X = 0; Bul2Y = MAP_H;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
